// File: rtl/master_port.sv
// Parallel-request to serial-bus master: handshakes with a memory slave, shifts one data word
// LSB-first over a shared tristate line, and returns a one-cycle response with timeout reporting.
module master_port #(
  parameter int unsigned ADDRESS_WIDTH = 12,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  input  logic                     req_write,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     req_ready,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_err,
  output logic [ADDRESS_WIDTH-1:0] slave_addr,
  output logic                     slave_write_en,
  input  logic                     slave_ready,
  input  logic                     slave_done,
  output logic                     bus_data_out,
  output logic                     bus_data_oe,
  input  logic                     bus_data_in
);

  localparam int unsigned CntW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0]  LastBit  = CntW'(DATA_WIDTH - 1);
  localparam logic [WaitW-1:0] LastWait = WaitW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    StIdle, StWaitRdy, StShiftWr, StShiftRd, StWaitDone, StResp
  } state_e;

  state_e                   state_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic                     write_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    rdata_q;
  logic [CntW-1:0]          bit_cnt_q;
  logic [WaitW-1:0]         wait_cnt_q;
  logic [DATA_WIDTH-1:0]    resp_rdata_q;
  logic                     resp_err_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      bit_cnt_q    <= '0;
      wait_cnt_q   <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid) begin
            addr_q     <= req_addr;
            write_q    <= req_write;
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
            wait_cnt_q <= '0;
            state_q    <= StWaitRdy;
          end
        end
        StWaitRdy: begin
          // The awaited event takes priority over a coincident timeout.
          if (slave_ready) begin
            bit_cnt_q <= '0;
            state_q   <= write_q ? StShiftWr : StShiftRd;
          end else if (wait_cnt_q == LastWait) begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StShiftWr, StShiftRd: begin
          if (state_q == StShiftRd) rdata_q[bit_cnt_q] <= bus_data_in;
          bit_cnt_q <= bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            wait_cnt_q <= '0;
            state_q    <= StWaitDone;
          end
        end
        StWaitDone: begin
          if (slave_done) begin
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? '0 : rdata_q;
            state_q      <= StResp;
          end else if (wait_cnt_q == LastWait) begin
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
            state_q      <= StResp;
          end else begin
            wait_cnt_q <= wait_cnt_q + WaitW'(1);
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Outputs decode registered state only, so reset releases the bus without waiting for a clock.
  assign req_ready      = (state_q == StIdle);
  assign resp_valid     = (state_q == StResp);
  assign resp_rdata     = resp_rdata_q;
  assign resp_err       = resp_err_q;
  assign slave_addr     = (state_q != StIdle) ? addr_q : '0;
  assign slave_write_en = (state_q != StIdle) & write_q;
  assign bus_data_oe    = (state_q == StShiftWr);
  assign bus_data_out   = bus_data_oe & wdata_q[bit_cnt_q];

endmodule

// File: tb/tb_master_port.sv
// Directed self-checking bench for master_port with default parameters.
module tb_master_port;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned TO = 64;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          req_ready, resp_valid, resp_err;
  logic [DW-1:0] resp_rdata;
  logic [AW-1:0] slave_addr;
  logic          slave_write_en, slave_ready, slave_done;
  logic          bus_data_out, bus_data_oe, bus_data_in;

  int errors = 0;
  int checks = 0;

  master_port #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (DW),
    .TIMEOUT      (TO)
  ) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_ready     (req_ready),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .slave_addr    (slave_addr),
    .slave_write_en(slave_write_en),
    .slave_ready   (slave_ready),
    .slave_done    (slave_done),
    .bus_data_out  (bus_data_out),
    .bus_data_oe   (bus_data_oe),
    .bus_data_in   (bus_data_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic shift_wr(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) begin
      chk("wr_oe", 32'(bus_data_oe), 32'd1);
      chk("wr_bit", 32'(bus_data_out), 32'(d[i]));
      tick();
    end
    chk("wr_oe_after", 32'(bus_data_oe), 32'd0);
  endtask

  task automatic shift_rd(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) begin
      bus_data_in = d[i];
      chk("rd_oe", 32'(bus_data_oe), 32'd0);
      tick();
    end
    bus_data_in = 1'b0;
  endtask

  task automatic wait_quiet(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, {30'd0, resp_valid, bus_data_oe}, 32'd0);
    end
  endtask

  task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    tick();
    req_valid = 1'b0;
    chk("busy_ready", 32'(req_ready), 32'd0);
    chk("slave_addr", 32'(slave_addr), 32'(a));
    chk("slave_we", 32'(slave_write_en), 32'(wr));
  endtask

  initial begin
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    slave_ready = 1'b0; slave_done = 1'b0; bus_data_in = 1'b0;

    // Reset state, before any clock edge.
    #3;
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_outs", {resp_valid, resp_err, bus_data_oe, bus_data_out, slave_write_en},
        32'd0);
    chk("rst_rdata", 32'(resp_rdata), 32'd0);
    chk("rst_addr", 32'(slave_addr), 32'd0);
    tick();
    rstn = 1'b1;

    // Write 0x123/0xA5, ready after two cycles, done one cycle after shifting.
    issue(1'b1, 12'h123, 8'hA5);
    chk("wr_wait_oe", 32'(bus_data_oe), 32'd0);
    tick();
    slave_ready = 1'b1;
    tick();
    slave_ready = 1'b0;
    shift_wr(8'hA5);
    slave_done = 1'b1;
    tick();
    slave_done = 1'b0;
    chk("wr_resp_valid", 32'(resp_valid), 32'd1);
    chk("wr_resp_err", 32'(resp_err), 32'd0);
    chk("wr_resp_rdata", 32'(resp_rdata), 32'd0);
    tick();
    chk("wr_pulse_end", 32'(resp_valid), 32'd0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    chk("idle_addr", {20'd0, slave_addr}, 32'd0);
    chk("idle_we", 32'(slave_write_en), 32'd0);

    // Read 0x7FF returning 0x3C at minimum latency.
    slave_ready = 1'b1;
    issue(1'b0, 12'h7FF, 8'h00);
    tick();
    slave_ready = 1'b0;
    shift_rd(8'h3C);
    slave_done = 1'b1;
    tick();
    slave_done = 1'b0;
    chk("rd_resp_valid", 32'(resp_valid), 32'd1);
    chk("rd_resp_rdata", 32'(resp_rdata), 32'h3C);
    chk("rd_resp_err", 32'(resp_err), 32'd0);
    tick();
    chk("rd_hold_rdata", 32'(resp_rdata), 32'h3C);

    // slave_ready never arrives: timeout TO cycles after entering WAIT_RDY.
    issue(1'b1, 12'h456, 8'hFF);
    wait_quiet(TO - 1, "to_rdy_quiet");
    tick();
    chk("to_rdy_valid", 32'(resp_valid), 32'd1);
    chk("to_rdy_err", 32'(resp_err), 32'd1);
    chk("to_rdy_rdata", 32'(resp_rdata), 32'd0);
    tick();

    // slave_ready arrives on the timeout cycle: transfer proceeds.
    issue(1'b0, 12'h001, 8'h00);
    wait_quiet(TO - 1, "edge_rdy_quiet");
    slave_ready = 1'b1;
    tick();
    slave_ready = 1'b0;
    chk("edge_rdy_shift", 32'(resp_valid), 32'd0);
    shift_rd(8'h81);
    slave_done = 1'b1;
    tick();
    slave_done = 1'b0;
    chk("edge_rdy_valid", 32'(resp_valid), 32'd1);
    chk("edge_rdy_err", 32'(resp_err), 32'd0);
    chk("edge_rdy_rdata", 32'(resp_rdata), 32'h81);
    tick();

    // slave_done never arrives: timeout out of WAIT_DONE; ready there is ignored.
    slave_ready = 1'b1;
    issue(1'b1, 12'h0F0, 8'h0F);
    tick();
    shift_wr(8'h0F);
    wait_quiet(TO - 1, "to_done_quiet");
    tick();
    slave_ready = 1'b0;
    chk("to_done_valid", 32'(resp_valid), 32'd1);
    chk("to_done_err", 32'(resp_err), 32'd1);
    tick();

    // Reset during write bit 4 releases the bus at once and drops the response.
    issue(1'b1, 12'h222, 8'hFF);
    slave_ready = 1'b1;
    tick();
    slave_ready = 1'b0;
    slave_done = 1'b1;
    repeat (4) tick();
    chk("b4_oe", 32'(bus_data_oe), 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("mid_rst_oe", {30'd0, bus_data_oe, bus_data_out}, 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_err", {23'd0, resp_err, resp_rdata}, 32'd0);
    slave_done = 1'b0;
    wait_quiet(2, "mid_rst_quiet");
    rstn = 1'b1;
    slave_ready = 1'b1;
    issue(1'b0, 12'h055, 8'h00);
    tick();
    slave_ready = 1'b0;
    shift_rd(8'h5A);
    slave_done = 1'b1;
    tick();
    slave_done = 1'b0;
    chk("post_rst_valid", 32'(resp_valid), 32'd1);
    chk("post_rst_rdata", 32'(resp_rdata), 32'h5A);
    tick();

    // Back-to-back writes with req_valid held and slave strobes held high.
    slave_ready = 1'b1;
    slave_done  = 1'b1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 12'h010; req_wdata = 8'h33;
    tick();
    req_addr = 12'h020; req_wdata = 8'hCC;
    chk("b2b_addr1", 32'(slave_addr), 32'h010);
    tick();
    shift_wr(8'h33);
    chk("b2b_busy_ready", 32'(req_ready), 32'd0);
    tick();
    chk("b2b_valid1", 32'(resp_valid), 32'd1);
    chk("b2b_noaccept", 32'(req_ready), 32'd0);
    tick();
    chk("b2b_idle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk("b2b_addr2", 32'(slave_addr), 32'h020);
    chk("b2b_valid_gap", 32'(resp_valid), 32'd0);
    tick();
    shift_wr(8'hCC);
    tick();
    chk("b2b_valid2", 32'(resp_valid), 32'd1);
    chk("b2b_err2", 32'(resp_err), 32'd0);
    slave_ready = 1'b0;
    slave_done  = 1'b0;
    tick();
    chk("b2b_final_idle", {30'd0, req_ready, resp_valid}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
